// File: rtl/mips_alu_arbiter_if.sv
// Shared types and the requester/ALU/response bundle for the round-robin
// arbiter that shares one combinational MIPS ALU between two requesters.
package mips_alu_arbiter_pkg;

   localparam int unsigned Data_Width  = 32;
   localparam int unsigned Shamt_Width = 5;
   localparam int unsigned Num_Req     = 2;

   typedef enum logic [3:0] {
      ADD_ALU_Sel  = 4'h0,
      SUB_ALU_Sel  = 4'h1,
      AND_ALU_Sel  = 4'h2,
      OR_ALU_Sel   = 4'h3,
      XOR_ALU_Sel  = 4'h4,
      NOR_ALU_Sel  = 4'h5,
      SLT_ALU_Sel  = 4'h6,
      SLTU_ALU_Sel = 4'h7,
      SLL_ALU_Sel  = 4'h8,
      SRL_ALU_Sel  = 4'h9,
      SRA_ALU_Sel  = 4'hA,
      SLLV_ALU_Sel = 4'hB,
      SRLV_ALU_Sel = 4'hC,
      SRAV_ALU_Sel = 4'hD,
      LUI_ALU_Sel  = 4'hE
   } alu_sel_t;

   typedef struct packed {
      alu_sel_t                sel;
      logic [Data_Width-1:0]   a;
      logic [Data_Width-1:0]   b;
      logic [Shamt_Width-1:0]  shamt;
   } alu_op_t;

   localparam alu_op_t Op_Reset = '{sel: ADD_ALU_Sel, a: '0, b: '0, shamt: '0};

endpackage

interface mips_alu_arbiter_if;
   import mips_alu_arbiter_pkg::*;

   logic [Num_Req-1:0]      req_valid;
   logic [Num_Req-1:0]      req_ready;
   alu_sel_t                req_sel0;
   alu_sel_t                req_sel1;
   logic [Data_Width-1:0]   req_a0;
   logic [Data_Width-1:0]   req_a1;
   logic [Data_Width-1:0]   req_b0;
   logic [Data_Width-1:0]   req_b1;
   logic [Shamt_Width-1:0]  req_shamt0;
   logic [Shamt_Width-1:0]  req_shamt1;

   alu_sel_t                alu_sel;
   logic [Data_Width-1:0]   alu_a;
   logic [Data_Width-1:0]   alu_b;
   logic [Shamt_Width-1:0]  alu_shamt;
   logic [Data_Width-1:0]   alu_result;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [Data_Width-1:0]   rsp_data;
   logic                    rsp_zero;
   logic                    rsp_id;

   // Arbiter side
   modport slave (
      input  req_valid, req_sel0, req_sel1, req_a0, req_a1,
             req_b0, req_b1, req_shamt0, req_shamt1,
      output req_ready,
      output alu_sel, alu_a, alu_b, alu_shamt,
      input  alu_result,
      output rsp_valid, rsp_data, rsp_zero, rsp_id,
      input  rsp_ready
   );

   // Requester / ALU / consumer side
   modport master (
      output req_valid, req_sel0, req_sel1, req_a0, req_a1,
             req_b0, req_b1, req_shamt0, req_shamt1,
      input  req_ready,
      input  alu_sel, alu_a, alu_b, alu_shamt,
      output alu_result,
      input  rsp_valid, rsp_data, rsp_zero, rsp_id,
      output rsp_ready
   );

endinterface

// File: rtl/mips_alu_arbiter.sv
// Round-robin arbiter sharing one combinational MIPS ALU between the execute
// stage (requester 0) and the multi-cycle helper (requester 1).
module mips_alu_arbiter
   import mips_alu_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   mips_alu_arbiter_if.slave   arb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    ptr_q, ptr_d;
   alu_op_t                 op_q, op_d;
   logic [Data_Width-1:0]   rsp_data_q, rsp_data_d;
   logic                    rsp_zero_q, rsp_zero_d;
   logic                    rsp_id_q, rsp_id_d;

   logic                    grant_c;
   logic                    accept_c;
   logic [Num_Req-1:0]      req_ready_c;
   alu_op_t                 cand_op_c;

   // With both requesters valid, ptr breaks the tie; otherwise the lone valid wins.
   always_comb begin
      grant_c         = (&arb.req_valid) ? ptr_q : arb.req_valid[1];
      accept_c        = (state_q == IDLE) && (|arb.req_valid);
      cand_op_c.sel   = grant_c ? arb.req_sel1   : arb.req_sel0;
      cand_op_c.a     = grant_c ? arb.req_a1     : arb.req_a0;
      cand_op_c.b     = grant_c ? arb.req_b1     : arb.req_b0;
      cand_op_c.shamt = grant_c ? arb.req_shamt1 : arb.req_shamt0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (arb.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_c = '0;
      ptr_d       = ptr_q;
      op_d        = op_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               req_ready_c[grant_c] = 1'b1;
               op_d                 = cand_op_c;
               rsp_id_d             = grant_c;
               ptr_d                = ~grant_c;
            end
         end
         EXEC: begin
            rsp_data_d = arb.alu_result;
            rsp_zero_d = (arb.alu_result == '0);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= 1'b0;
         op_q       <= Op_Reset;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b1;
         rsp_id_q   <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         op_q       <= op_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign arb.req_ready = req_ready_c;
   assign arb.alu_sel   = op_q.sel;
   assign arb.alu_a     = op_q.a;
   assign arb.alu_b     = op_q.b;
   assign arb.alu_shamt = op_q.shamt;
   assign arb.rsp_valid = (state_q == RESP);
   assign arb.rsp_data  = rsp_data_q;
   assign arb.rsp_zero  = rsp_zero_q;
   assign arb.rsp_id    = rsp_id_q;

   // A stalled response must leave every visible register untouched.
   ready_onehot_a: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready_c));

   resp_stall_a: assert property (@(posedge clk) disable iff (rst)
      (state_q == RESP && !arb.rsp_ready) |=>
         (state_q == RESP && $stable(rsp_data_q) && $stable(rsp_id_q) && $stable(op_q)));

endmodule

// File: tb/tb_mips_alu_arbiter.sv
// Directed bench for mips_alu_arbiter with a behavioural MIPS ALU on the alu_* bus.
module tb_mips_alu_arbiter;
   import mips_alu_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mips_alu_arbiter_if bus ();

   mips_alu_arbiter dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(alu_sel_t s, logic [31:0] a, logic [31:0] b,
                                             logic [4:0] sh);
      case (s)
         ADD_ALU_Sel:  return a + b;
         SUB_ALU_Sel:  return a - b;
         AND_ALU_Sel:  return a & b;
         OR_ALU_Sel:   return a | b;
         XOR_ALU_Sel:  return a ^ b;
         NOR_ALU_Sel:  return ~(a | b);
         SLT_ALU_Sel:  return {31'd0, $signed(a) < $signed(b)};
         SLTU_ALU_Sel: return {31'd0, a < b};
         SLL_ALU_Sel:  return b << sh;
         SRL_ALU_Sel:  return b >> sh;
         SRA_ALU_Sel:  return 32'($signed(b) >>> sh);
         SLLV_ALU_Sel: return b << a[4:0];
         SRLV_ALU_Sel: return b >> a[4:0];
         SRAV_ALU_Sel: return 32'($signed(b) >>> a[4:0]);
         LUI_ALU_Sel:  return {b[15:0], 16'h0000};
         default:      return 32'h0;
      endcase
   endfunction

   always_comb bus.alu_result = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_shamt);

   task automatic idle_inputs();
      bus.req_valid  = 2'b00;
      bus.req_sel0   = ADD_ALU_Sel;
      bus.req_sel1   = ADD_ALU_Sel;
      bus.req_a0     = '0;
      bus.req_a1     = '0;
      bus.req_b0     = '0;
      bus.req_b1     = '0;
      bus.req_shamt0 = '0;
      bus.req_shamt1 = '0;
      bus.rsp_ready  = 1'b1;
   endtask

   // Bounded wait for rsp_valid, sampled on falling edges.
   task automatic wait_rsp(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.rsp_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL reset_rsp_zero got %b exp 1", bus.rsp_zero); end
      checks++; if (bus.alu_sel !== ADD_ALU_Sel) begin errors++; $display("FAIL reset_alu_sel got %h exp %h", bus.alu_sel, ADD_ALU_Sel); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alu_shamt} !== 69'd0) begin errors++; $display("FAIL reset_alu_ops got %h/%h/%h exp 0", bus.alu_a, bus.alu_b, bus.alu_shamt); end
      checks++; if ({bus.rsp_data, bus.rsp_id} !== 33'd0) begin errors++; $display("FAIL reset_rsp_data_id got %h/%b exp 0/0", bus.rsp_data, bus.rsp_id); end
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_sel0 = ADD_ALU_Sel; bus.req_a0 = 32'd5; bus.req_b0 = 32'd7;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec got ready=%b valid=%b exp 00/0", bus.req_ready, bus.rsp_valid); end
      checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin errors++; $display("FAIL single_alu_ops got %0d/%0d exp 5/7", bus.alu_a, bus.alu_b); end
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'd12 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp got data=%0d zero=%b id=%b exp 12/0/0", bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_done got %b exp 0", bus.rsp_valid); end
   endtask

   task automatic test_zero_flag();
      bit ok; int cyc;
      @(negedge clk);
      bus.req_valid = 2'b10; bus.req_sel1 = SUB_ALU_Sel; bus.req_a1 = 32'd9; bus.req_b1 = 32'd9;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL zero_ready got %b exp 10", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got no rsp_valid exp rsp_valid=1"); end
      checks++; if (bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL zero_rsp got data=%h zero=%b id=%b exp 0/1/1", bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
   endtask

   task automatic test_contention();
      bit ok; int cyc;
      logic        exp_id   [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] exp_data [3] = '{32'd7, 32'hFF, 32'd7};
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.req_sel0 = SUB_ALU_Sel; bus.req_a0 = 32'd10;   bus.req_b0 = 32'd3;
      bus.req_sel1 = OR_ALU_Sel;  bus.req_a1 = 32'hF0;   bus.req_b1 = 32'h0F;
      for (int k = 0; k < 3; k++) begin
         wait_rsp(ok, cyc);
         checks++; if (!ok) begin errors++; $display("FAIL contend_timeout[%0d] got no rsp_valid exp rsp_valid=1", k); end
         checks++; if (bus.rsp_id !== exp_id[k] || bus.rsp_data !== exp_data[k]) begin errors++; $display("FAIL contend_rsp[%0d] got id=%b data=%h exp %b/%h", k, bus.rsp_id, bus.rsp_data, exp_id[k], exp_data[k]); end
         if (k > 0) begin
            checks++; if (cyc != 3) begin errors++; $display("FAIL contend_spacing[%0d] got %0d exp 3", k, cyc); end
         end
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      bit ok; int cyc;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_sel0 = XOR_ALU_Sel; bus.req_a0 = 32'hFF;  bus.req_b0 = 32'h0F;
      bus.req_sel1 = ADD_ALU_Sel; bus.req_a1 = 32'd100; bus.req_b1 = 32'd23;
      wait_rsp(ok, cyc);
      checks++; if (!ok || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'd123) begin errors++; $display("FAIL bp_first got ok=%b id=%b data=%0d exp 1/1/123", ok, bus.rsp_id, bus.rsp_data); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd123 || bus.req_ready !== 2'b00 || bus.alu_a !== 32'd100) begin errors++; $display("FAIL bp_stall[%0d] got valid=%b data=%0d ready=%b alu_a=%0d exp 1/123/00/100", k, bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.alu_a); end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_regrant got ready=%b valid=%b exp 01/0", bus.req_ready, bus.rsp_valid); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(ok, cyc);
      checks++; if (!ok || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'hF0) begin errors++; $display("FAIL bp_second got ok=%b id=%b data=%h exp 1/0/f0", ok, bus.rsp_id, bus.rsp_data); end
   endtask

   task automatic test_shift();
      bit ok; int cyc;
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_sel0 = SRAV_ALU_Sel;
      bus.req_a0 = 32'd4; bus.req_b0 = 32'h8000_0000; bus.req_shamt0 = 5'd0;
      @(negedge clk);
      bus.req_valid = 2'b00; bus.req_a0 = 32'd1;
      wait_rsp(ok, cyc);
      checks++; if (!ok || bus.rsp_data !== 32'hF800_0000) begin errors++; $display("FAIL srav got ok=%b data=%h exp 1/f8000000", ok, bus.rsp_data); end
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_sel0 = SRL_ALU_Sel;
      bus.req_a0 = 32'd0; bus.req_b0 = 32'h8000_0000; bus.req_shamt0 = 5'd4;
      @(negedge clk);
      bus.req_valid = 2'b00; bus.req_shamt0 = 5'd31;
      wait_rsp(ok, cyc);
      checks++; if (!ok || bus.rsp_data !== 32'h0800_0000 || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL srl got ok=%b data=%h zero=%b exp 1/08000000/0", ok, bus.rsp_data, bus.rsp_zero); end
   endtask

   task automatic test_reset_midop();
      bit ok; int cyc; int seen;
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_sel0 = SUB_ALU_Sel; bus.req_a0 = 32'd5; bus.req_b0 = 32'd1;
      @(negedge clk);
      bus.req_valid = 2'b00;
      checks++; if (bus.alu_sel !== SUB_ALU_Sel) begin errors++; $display("FAIL midop_loaded got %h exp %h", bus.alu_sel, SUB_ALU_Sel); end
      rst = 1'b1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.alu_sel !== ADD_ALU_Sel || bus.alu_a !== 32'd0) begin errors++; $display("FAIL midop_reset got valid=%b sel=%h a=%0d exp 0/0/0", bus.rsp_valid, bus.alu_sel, bus.alu_a); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midop_no_rsp got %0d responses exp 0", seen); end
      bus.req_valid = 2'b11;
      bus.req_sel0 = AND_ALU_Sel; bus.req_a0 = 32'hF0; bus.req_b0 = 32'h3C;
      bus.req_sel1 = ADD_ALU_Sel; bus.req_a1 = 32'd1;  bus.req_b1 = 32'd1;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midop_ptr got ready=%b exp 01", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(ok, cyc);
      checks++; if (!ok || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h30) begin errors++; $display("FAIL midop_after got ok=%b id=%b data=%h exp 1/0/30", ok, bus.rsp_id, bus.rsp_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_flag();
      test_contention();
      test_backpressure();
      test_shift();
      test_reset_midop();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
